// File: rtl/fft_frame_sequencer.sv
// Frame sequencer in front of the FFT pipeline: gates 4-lane sample words under start/stop/sync
// control and stamps each word with its in-frame index.
module fft_frame_sequencer #(
    parameter int unsigned BITWIDTH  = 7,
    parameter int unsigned FFT_POINT = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sync_sel,
    input  logic                  ext_sync,
    input  logic                  din_valid,
    input  logic [15:0]           din0,
    input  logic [15:0]           din1,
    input  logic [15:0]           din2,
    input  logic [15:0]           din3,
    output logic                  en_sync_out,
    output logic [BITWIDTH+1:0]   cnt_sync_out,
    output logic [15:0]           dout0,
    output logic [15:0]           dout1,
    output logic [15:0]           dout2,
    output logic [15:0]           dout3,
    output logic                  busy,
    output logic [31:0]           frame_cnt,
    output logic                  gap_err
);

    localparam int unsigned IDX_W    = BITWIDTH + 2;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned FCNT_W   = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINT - 4);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 en_d;
    logic [IDX_W-1:0]     cnt_d;
    logic [SAMPLE_W-1:0]  dout0_d, dout1_d, dout2_d, dout3_d;
    logic [FCNT_W-1:0]    frame_d;
    logic                 gap_d;
    logic                 active;

    logic                 sync_s1, sync_s2, sync_s3, sync_rise;

    // ext_sync synchronizer and registered rising-edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_s1   <= 1'b0;
            sync_s2   <= 1'b0;
            sync_s3   <= 1'b0;
            sync_rise <= 1'b0;
        end else begin
            sync_s1   <= ext_sync;
            sync_s2   <= sync_s1;
            sync_s3   <= sync_s2;
            sync_rise <= sync_s2 & ~sync_s3;
        end
    end

    // Next-state, index and output-word computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = 1'b0;
        cnt_d   = cnt_sync_out;
        dout0_d = dout0;
        dout1_d = dout1;
        dout2_d = dout2;
        dout3_d = dout3;
        frame_d = frame_cnt;
        gap_d   = gap_err;
        active  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = ARM;
                    idx_d   = '0;
                    frame_d = '0;
                    gap_d   = 1'b0;
                end
            end
            ARM: begin
                if (stop)
                    state_d = IDLE;
                else if (!sync_sel || sync_rise)
                    state_d = RUN;
            end
            RUN: begin
                active = 1'b1;
                if (stop)
                    state_d = (idx_q == '0 && !din_valid) ? IDLE : DRAIN;
            end
            DRAIN: begin
                // Index 0 here means the stop edge itself closed the frame
                if (idx_q == '0) begin
                    state_d = IDLE;
                end else begin
                    active = 1'b1;
                    if (din_valid && idx_q == LAST_IDX)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (active) begin
            if (din_valid) begin
                en_d    = 1'b1;
                cnt_d   = idx_q;
                dout0_d = din0;
                dout1_d = din1;
                dout2_d = din2;
                dout3_d = din3;
                idx_d   = idx_q + IDX_STEP;
                if (idx_q == LAST_IDX && frame_cnt != '1)
                    frame_d = frame_cnt + FCNT_W'(1);
            end else if (idx_q != '0) begin
                gap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            busy         <= 1'b0;
            en_sync_out  <= 1'b0;
            cnt_sync_out <= '0;
            dout0        <= '0;
            dout1        <= '0;
            dout2        <= '0;
            dout3        <= '0;
            frame_cnt    <= '0;
            gap_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy         <= (state_d != IDLE);
            en_sync_out  <= en_d;
            cnt_sync_out <= cnt_d;
            dout0        <= dout0_d;
            dout1        <= dout1_d;
            dout2        <= dout2_d;
            dout3        <= dout3_d;
            frame_cnt    <= frame_d;
            gap_err      <= gap_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed self-checking bench for fft_frame_sequencer (BITWIDTH=7, FFT_POINT=512).
module tb_fft_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, sync_sel, ext_sync, din_valid;
    logic [15:0] din0, din1, din2, din3;
    logic        en_sync_out;
    logic [8:0]  cnt_sync_out;
    logic [15:0] dout0, dout1, dout2, dout3;
    logic        busy;
    logic [31:0] frame_cnt;
    logic        gap_err;

    int checks = 0;
    int errors = 0;

    fft_frame_sequencer #(.BITWIDTH(7), .FFT_POINT(512)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sync_sel(sync_sel),
        .ext_sync(ext_sync), .din_valid(din_valid),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .en_sync_out(en_sync_out), .cnt_sync_out(cnt_sync_out),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .busy(busy), .frame_cnt(frame_cnt), .gap_err(gap_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int unsigned k);
        din_valid = 1'b1;
        din0 = 16'(4 * k);
        din1 = 16'(4 * k + 1);
        din2 = 16'(4 * k + 2);
        din3 = 16'(4 * k + 3);
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; sync_sel = 1'b0; ext_sync = 1'b0; din_valid = 1'b0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    // start with sync_sel=0; returns with the sequencer in RUN, index 0
    task automatic arm_free();
        sync_sel = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #12;
        checks++;
        if ({en_sync_out, cnt_sync_out, dout0, dout1, dout2, dout3, busy, frame_cnt, gap_err} !== '0) begin
            errors++;
            $display("FAIL reset_initial: en=%b cnt=%0d d0=%0h busy=%b frames=%0d gap=%b, all required 0",
                     en_sync_out, cnt_sync_out, dout0, busy, frame_cnt, gap_err);
        end
        rst = 1'b1;
        tick();
        arm_free();
        for (int k = 0; k < 10; k++) begin put_word(k); tick(); end
        din_valid = 1'b0;
        tick();
        for (int k = 10; k < 50; k++) begin put_word(k); tick(); end
        checks++;
        if (cnt_sync_out !== 9'd196 || gap_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: cnt=%0d gap=%b busy=%b, required cnt=196 gap=1 busy=1",
                     cnt_sync_out, gap_err, busy);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({en_sync_out, cnt_sync_out, dout0, dout1, dout2, dout3, busy, frame_cnt, gap_err} !== '0) begin
            errors++;
            $display("FAIL reset_async: en=%b cnt=%0d d0=%0h d3=%0h busy=%b frames=%0d gap=%b, all required 0",
                     en_sync_out, cnt_sync_out, dout0, dout3, busy, frame_cnt, gap_err);
        end
        #2;
        idle_inputs();
        rst = 1'b1;
        tick();
        arm_free();
        put_word(7);
        tick();
        checks++;
        if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'd0 || dout0 !== 16'd28) begin
            errors++;
            $display("FAIL reset_restart: en=%b cnt=%0d d0=%0d, required en=1 cnt=0 d0=28",
                     en_sync_out, cnt_sync_out, dout0);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        arm_free();
        checks++;
        if (busy !== 1'b1 || en_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL free_arm: busy=%b en=%b, required busy=1 en=0", busy, en_sync_out);
        end
        for (int k = 0; k < 128; k++) begin
            put_word(k);
            tick();
            checks++;
            if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'(4 * k) || dout0 !== 16'(4 * k) ||
                dout3 !== 16'(4 * k + 3) || frame_cnt !== ((k == 127) ? 32'd1 : 32'd0)) begin
                errors++;
                $display("FAIL free_word%0d: en=%b cnt=%0d d0=%0d d3=%0d frames=%0d, required en=1 cnt=%0d d0=%0d d3=%0d",
                         k, en_sync_out, cnt_sync_out, dout0, dout3, frame_cnt, 4 * k, 4 * k, 4 * k + 3);
            end
        end
        put_word(128);
        tick();
        checks++;
        if (cnt_sync_out !== 9'd0 || dout0 !== 16'd512 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL free_wrap: cnt=%0d d0=%0d frames=%0d, required cnt=0 d0=512 frames=1",
                     cnt_sync_out, dout0, frame_cnt);
        end
        din_valid = 1'b0;
        tick();
        checks++;
        if (en_sync_out !== 1'b0 || cnt_sync_out !== 9'd0 || dout0 !== 16'd512) begin
            errors++;
            $display("FAIL free_hold: en=%b cnt=%0d d0=%0d, required en=0 cnt=0 d0=512",
                     en_sync_out, cnt_sync_out, dout0);
        end
    endtask

    task automatic test_sync_arm();
        int unsigned k;
        do_reset();
        sync_sel = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            put_word(k); k++;
            tick();
            checks++;
            if (en_sync_out !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL sync_wait%0d: en=%b busy=%b, required en=0 busy=1", i, en_sync_out, busy);
            end
        end
        ext_sync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put_word(k); k++;
            tick();
            checks++;
            if (en_sync_out !== 1'b0) begin
                errors++;
                $display("FAIL sync_edge%0d: en=%b, required 0", i, en_sync_out);
            end
        end
        put_word(k);
        tick();
        checks++;
        if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'd0 || dout0 !== 16'(4 * k)) begin
            errors++;
            $display("FAIL sync_first: en=%b cnt=%0d d0=%0d, required en=1 cnt=0 d0=%0d",
                     en_sync_out, cnt_sync_out, dout0, 4 * k);
        end
        for (int j = 1; j <= 20; j++) begin
            ext_sync = (j >= 8 && j < 12);
            k++;
            put_word(k);
            tick();
            checks++;
            if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'(4 * j)) begin
                errors++;
                $display("FAIL sync_run%0d: en=%b cnt=%0d, required en=1 cnt=%0d",
                         j, en_sync_out, cnt_sync_out, 4 * j);
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        arm_free();
        for (int k = 0; k < 25; k++) begin put_word(k); tick(); end
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (en_sync_out !== 1'b0 || cnt_sync_out !== 9'd96 || gap_err !== 1'b1) begin
                errors++;
                $display("FAIL gap_cycle%0d: en=%b cnt=%0d gap=%b, required en=0 cnt=96 gap=1",
                         i, en_sync_out, cnt_sync_out, gap_err);
            end
        end
        put_word(25);
        tick();
        checks++;
        if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'd100 || dout0 !== 16'd100 || gap_err !== 1'b1) begin
            errors++;
            $display("FAIL gap_resume: en=%b cnt=%0d d0=%0d gap=%b, required en=1 cnt=100 d0=100 gap=1",
                     en_sync_out, cnt_sync_out, dout0, gap_err);
        end
        do_reset();
        arm_free();
        din_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (gap_err !== 1'b0 || en_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL gap_at_zero: gap=%b en=%b, required gap=0 en=0", gap_err, en_sync_out);
        end
        put_word(0);
        tick();
        checks++;
        if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'd0 || gap_err !== 1'b0) begin
            errors++;
            $display("FAIL gap_zero_resume: en=%b cnt=%0d gap=%b, required en=1 cnt=0 gap=0",
                     en_sync_out, cnt_sync_out, gap_err);
        end
    endtask

    task automatic test_stop_drain();
        do_reset();
        arm_free();
        for (int k = 0; k < 128; k++) begin put_word(k); tick(); end
        for (int k = 0; k < 65; k++) begin put_word(k); tick(); end
        checks++;
        if (frame_cnt !== 32'd1 || cnt_sync_out !== 9'd256) begin
            errors++;
            $display("FAIL drain_pre: frames=%0d cnt=%0d, required frames=1 cnt=256", frame_cnt, cnt_sync_out);
        end
        put_word(65);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'd260 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_stop: en=%b cnt=%0d busy=%b, required en=1 cnt=260 busy=1",
                     en_sync_out, cnt_sync_out, busy);
        end
        for (int k = 66; k < 128; k++) begin
            put_word(k);
            tick();
            checks++;
            if (en_sync_out !== 1'b1 || cnt_sync_out !== 9'(4 * k) || busy !== (k != 127)) begin
                errors++;
                $display("FAIL drain_word%0d: en=%b cnt=%0d busy=%b, required en=1 cnt=%0d busy=%b",
                         k, en_sync_out, cnt_sync_out, busy, 4 * k, (k != 127));
            end
        end
        checks++;
        if (frame_cnt !== 32'd2) begin
            errors++;
            $display("FAIL drain_frames: frames=%0d, required 2", frame_cnt);
        end
        put_word(0);
        tick();
        checks++;
        if (en_sync_out !== 1'b0 || busy !== 1'b0 || cnt_sync_out !== 9'd508) begin
            errors++;
            $display("FAIL drain_after: en=%b busy=%b cnt=%0d, required en=0 busy=0 cnt=508",
                     en_sync_out, busy, cnt_sync_out);
        end
        do_reset();
        arm_free();
        din_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || en_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL stop_zero: busy=%b en=%b, required busy=0 en=0", busy, en_sync_out);
        end
        put_word(3);
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || en_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL stop_zero_quiet: busy=%b en=%b, required busy=0 en=0", busy, en_sync_out);
        end
    endtask

    task automatic test_control();
        do_reset();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        put_word(1);
        tick();
        checks++;
        if (busy !== 1'b0 || en_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL ctl_start_stop: busy=%b en=%b, required busy=0 en=0", busy, en_sync_out);
        end
        din_valid = 1'b0;
        arm_free();
        for (int k = 0; k < 128; k++) begin put_word(k); tick(); end
        put_word(128);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (frame_cnt !== 32'd1 || busy !== 1'b1 || en_sync_out !== 1'b1 || cnt_sync_out !== 9'd0) begin
            errors++;
            $display("FAIL ctl_start_run: frames=%0d busy=%b en=%b cnt=%0d, required frames=1 busy=1 en=1 cnt=0",
                     frame_cnt, busy, en_sync_out, cnt_sync_out);
        end
        put_word(129);
        tick();
        checks++;
        if (cnt_sync_out !== 9'd4 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL ctl_start_run_next: cnt=%0d frames=%0d, required cnt=4 frames=1",
                     cnt_sync_out, frame_cnt);
        end
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b1;
        put_word(0);
        tick();
        stop = 1'b0;
        put_word(1);
        tick();
        checks++;
        if (busy !== 1'b0 || en_sync_out !== 1'b0) begin
            errors++;
            $display("FAIL ctl_stop_arm: busy=%b en=%b, required busy=0 en=0", busy, en_sync_out);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_sync_arm();
        test_gap();
        test_stop_drain();
        test_control();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
